// File: rtl/bat_amateur_mem_dump_if.sv
`default_nettype none
// ============================================================================
//  Module      : bat_amateur_mem_dump_if
//  Description : Signal bundle between the RAM dump master and its
//                surroundings. Carries the control request (start/abort and
//                address range), the shared RAM bus, and the output word
//                stream.
//                master modport : the dump block
//                slave  modport : system side (CPU halt, RAM, stream sink)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bat_amateur_mem_dump_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 16
);
    // Control request
    logic                     start;
    logic                     abort;
    logic [ADDRESS_WIDTH-1:0] start_addr;
    logic [ADDRESS_WIDTH-1:0] end_addr;
    // CPU and shared RAM bus
    logic                     halt;
    logic                     bus_oe;
    logic [ADDRESS_WIDTH-1:0] address_bus;
    logic                     ram_en;
    logic                     ram_rw;
    logic [DATA_WIDTH-1:0]    data_bus;
    // Output stream and status
    logic [DATA_WIDTH-1:0]    dump_data;
    logic [ADDRESS_WIDTH-1:0] dump_addr;
    logic                     dump_valid;
    logic                     dump_ready;
    logic                     busy;
    logic                     done;

    modport master (
        input  start, abort, start_addr, end_addr, data_bus, dump_ready,
        output halt, bus_oe, address_bus, ram_en, ram_rw,
               dump_data, dump_addr, dump_valid, busy, done
    );

    modport slave (
        output start, abort, start_addr, end_addr, data_bus, dump_ready,
        input  halt, bus_oe, address_bus, ram_en, ram_rw,
               dump_data, dump_addr, dump_valid, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/bat_amateur_mem_dump.sv
`default_nettype none
// ============================================================================
//  Module      : bat_amateur_mem_dump
//  Description : RAM readback master. Halts the CPU, waits for it to settle,
//                takes the shared RAM bus and reads an inclusive address
//                range, streaming each word out over valid/ready.
//  Ports       : clk_i  - system clock, rising edge
//                rst_i  - synchronous active-high reset
//                bus    - bat_amateur_mem_dump_if.master (request, RAM bus,
//                         output stream, busy/done status)
//  Revision    : 1.0 - initial release
// ============================================================================
module bat_amateur_mem_dump #(
    parameter int ADDRESS_WIDTH    = 16,
    parameter int DATA_WIDTH       = 16,
    parameter int RAM_READ_LATENCY = 1,
    parameter int HALT_SETTLE      = 2
) (
    input wire                     clk_i,
    input wire                     rst_i,
    bat_amateur_mem_dump_if.master bus
);

    // One down-counter serves both the settle wait and the read latency.
    localparam int CNT_MAX = (HALT_SETTLE > RAM_READ_LATENCY) ? HALT_SETTLE : RAM_READ_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]         SETTLE_LOAD = CNT_W'(HALT_SETTLE);
    localparam logic [CNT_W-1:0]         LAT_LOAD    = CNT_W'(RAM_READ_LATENCY);
    localparam logic [CNT_W-1:0]         CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE    = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_READ    = 3'd2,
        S_OUT     = 3'd3,
        S_RELEASE = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cur_q, cur_d;
    logic [ADDRESS_WIDTH-1:0] last_q, last_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    dump_data_q, dump_data_d;
    logic [ADDRESS_WIDTH-1:0] dump_addr_q, dump_addr_d;

    logic                     halt_q, halt_d;
    logic                     bus_oe_q, bus_oe_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic                     ram_en_q, ram_en_d;
    logic                     ram_rw_q;
    logic                     dump_valid_q, dump_valid_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        dump_data_d = dump_data_q;
        dump_addr_d = dump_addr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cur_d   = bus.start_addr;
                    last_d  = bus.end_addr;
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_ONE) begin
                    cnt_d   = LAT_LOAD;
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_READ: begin
                if (bus.abort) begin
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_ONE) begin
                    dump_data_d = bus.data_bus;
                    dump_addr_d = cur_q;
                    state_d     = S_OUT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_OUT: begin
                // dump_valid is always high here, so ready alone is the
                // handshake. An abort on the handshake cycle still lets the
                // word count as delivered; it just stops further reads.
                if (bus.abort || (bus.dump_ready && (cur_q == last_q))) begin
                    state_d = S_RELEASE;
                end else if (bus.dump_ready) begin
                    cur_d   = cur_q + ADDR_ONE;
                    cnt_d   = LAT_LOAD;
                    state_d = S_READ;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode from the next state, so every output is registered
    // and lines up with the state it belongs to.
    // ------------------------------------------------------------------
    always_comb begin
        halt_d       = 1'b0;
        bus_oe_d     = 1'b0;
        address_d    = '0;
        ram_en_d     = 1'b0;
        dump_valid_d = 1'b0;
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_RELEASE);

        case (state_d)
            S_SETTLE: begin
                halt_d = 1'b1;
            end
            S_READ: begin
                halt_d    = 1'b1;
                bus_oe_d  = 1'b1;
                ram_en_d  = 1'b1;
                address_d = cur_d;
            end
            S_OUT: begin
                halt_d       = 1'b1;
                bus_oe_d     = 1'b1;
                address_d    = cur_d;
                dump_valid_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            last_q       <= '0;
            cnt_q        <= '0;
            dump_data_q  <= '0;
            dump_addr_q  <= '0;
            halt_q       <= 1'b0;
            bus_oe_q     <= 1'b0;
            address_q    <= '0;
            ram_en_q     <= 1'b0;
            ram_rw_q     <= 1'b1;
            dump_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            dump_data_q  <= dump_data_d;
            dump_addr_q  <= dump_addr_d;
            halt_q       <= halt_d;
            bus_oe_q     <= bus_oe_d;
            address_q    <= address_d;
            ram_en_q     <= ram_en_d;
            ram_rw_q     <= 1'b1;   // read-only master
            dump_valid_q <= dump_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.halt        = halt_q;
    assign bus.bus_oe      = bus_oe_q;
    assign bus.address_bus = address_q;
    assign bus.ram_en      = ram_en_q;
    assign bus.ram_rw      = ram_rw_q;
    assign bus.dump_data   = dump_data_q;
    assign bus.dump_addr   = dump_addr_q;
    assign bus.dump_valid  = dump_valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bat_amateur_mem_dump.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bat_amateur_mem_dump
//  Description : Self-checking bench for bat_amateur_mem_dump. A RAM array
//                answers reads; the expected beat list for each range is
//                built directly from the range arithmetic and the array.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bat_amateur_mem_dump;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int LAT = 1;
    localparam int HS  = 2;

    logic clk;
    logic rst;

    bat_amateur_mem_dump_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bat_amateur_mem_dump #(
        .ADDRESS_WIDTH   (AW),
        .DATA_WIDTH      (DW),
        .RAM_READ_LATENCY(LAT),
        .HALT_SETTLE     (HS)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: asynchronous read of the presented address while enabled.
    logic [DW-1:0] mem [0:65535];
    always_comb bus.data_bus = bus.ram_en ? mem[bus.address_bus] : 16'hDEAD;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [AW-1:0] got_addr[$];
    logic [DW-1:0] got_data[$];
    int            hs_cyc[$];
    int            done_cnt;
    int            done_cyc;
    logic          done_halt, done_oe, done_valid;

    typedef struct {
        logic [AW-1:0] s;
        logic [AW-1:0] e;
        int            exp_words;
        logic [AW-1:0] exp_last;
        bit            rnd_ready;
        int            stall_beat;
        bit            glitch;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: log a handshake about to happen, advance, then sample.
    task automatic tick();
        if (bus.dump_valid && bus.dump_ready) begin
            got_addr.push_back(bus.dump_addr);
            got_data.push_back(bus.dump_data);
            hs_cyc.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (bus.done) begin
            done_cnt++;
            done_cyc   = cyc;
            done_halt  = bus.halt;
            done_oe    = bus.bus_oe;
            done_valid = bus.dump_valid;
        end
        if (bus.bus_oe && !bus.halt) chk("oe_without_halt", 1, 0);
    endtask

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
        hs_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_halt"},   bus.halt, 0);
        chk({tag, "_oe"},     bus.bus_oe, 0);
        chk({tag, "_addr"},   bus.address_bus, 0);
        chk({tag, "_ram_en"}, bus.ram_en, 0);
        chk({tag, "_ram_rw"}, bus.ram_rw, 1);
        chk({tag, "_ddata"},  bus.dump_data, 0);
        chk({tag, "_daddr"},  bus.dump_addr, 0);
        chk({tag, "_valid"},  bus.dump_valid, 0);
        chk({tag, "_busy"},   bus.busy, 0);
        chk({tag, "_done"},   bus.done, 0);
    endtask

    task automatic run_dump(input vec_t v);
        logic [AW-1:0] ea[$];
        logic [DW-1:0] ed[$];
        logic [AW-1:0] span;
        logic [AW-1:0] a;
        int n, c0, guard, stall, first_valid;

        // Reference: word count is the modular span plus one.
        span = v.e - v.s;
        n    = int'(span) + 1;
        for (int i = 0; i < n; i++) begin
            a = v.s + i[AW-1:0];
            ea.push_back(a);
            ed.push_back(mem[a]);
        end

        clear_log();
        stall       = 0;
        first_valid = -1;
        bus.start_addr = v.s;
        bus.end_addr   = v.e;
        bus.dump_ready = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        c0 = cyc;
        chk("start_busy", bus.busy, 1);
        chk("start_halt", bus.halt, 1);
        chk("start_oe",   bus.bus_oe, 0);

        guard = 0;
        while (done_cnt == 0 && guard < 2000) begin
            bus.start      = 1'b0;
            bus.start_addr = v.s;
            bus.end_addr   = v.e;
            if (first_valid < 0 && bus.dump_valid) first_valid = cyc;
            if (v.stall_beat >= 0 && bus.dump_valid && got_addr.size() == v.stall_beat && stall < 5) begin
                bus.dump_ready = 1'b0;
                chk("stall_daddr",  bus.dump_addr, ea[v.stall_beat]);
                chk("stall_ddata",  bus.dump_data, ed[v.stall_beat]);
                chk("stall_ram_en", bus.ram_en, 0);
                chk("stall_halt",   bus.halt, 1);
                chk("stall_abus",   bus.address_bus, ea[v.stall_beat]);
                stall++;
            end else begin
                bus.dump_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (v.glitch && cyc == c0 + 3) begin
                bus.start      = 1'b1;
                bus.start_addr = ~v.s;
                bus.end_addr   = ~v.e;
            end
            tick();
            guard++;
        end
        bus.start      = 1'b0;
        bus.start_addr = v.s;
        bus.end_addr   = v.e;

        chk("done_seen", done_cnt, 1);
        chk("done_halt", done_halt, 0);
        chk("done_oe",   done_oe, 0);
        chk("done_valid", done_valid, 0);
        chk("words_model", got_addr.size(), n);
        chk("words_table", got_addr.size(), v.exp_words);
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            chk("beat_addr", got_addr[i], ea[i]);
            chk("beat_data", got_data[i], ed[i]);
        end
        if (got_addr.size() > 0) begin
            chk("last_addr", got_addr[got_addr.size()-1], v.exp_last);
            chk("done_after_hs", done_cyc, hs_cyc[hs_cyc.size()-1]);
        end
        chk("first_valid_cycle", first_valid, c0 + HS + LAT);
        if (!v.rnd_ready && v.stall_beat < 0) begin
            for (int i = 1; i < hs_cyc.size(); i++)
                chk("beat_spacing", hs_cyc[i] - hs_cyc[i-1], LAT + 1);
        end
        if (v.stall_beat >= 0) chk("stall_len", stall, 5);

        tick();
        chk("idle_busy", bus.busy, 0);
        chk("single_done", done_cnt, 1);
    endtask

    vec_t tbl[6];

    initial begin
        vec_t rv;
        int   guard;
        logic [AW-1:0] rs;
        int   len;

        tbl[0] = '{16'h0010, 16'h0012,  3, 16'h0012, 1'b0, -1, 1'b0};
        tbl[1] = '{16'h0005, 16'h0005,  1, 16'h0005, 1'b0, -1, 1'b0};
        tbl[2] = '{16'hFFFE, 16'h0001,  4, 16'h0001, 1'b0, -1, 1'b0};
        tbl[3] = '{16'h0030, 16'h0033,  4, 16'h0033, 1'b0,  1, 1'b0};
        tbl[4] = '{16'h0020, 16'h0022,  3, 16'h0022, 1'b0, -1, 1'b1};
        tbl[5] = '{16'h1234, 16'h1240, 13, 16'h1240, 1'b1, -1, 1'b0};

        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0010] = 16'd1;
        mem[16'h0011] = 16'd0;
        mem[16'h0012] = 16'd1;

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.start_addr = '0;
        bus.end_addr   = '0;
        bus.dump_ready = 1'b0;
        clear_log();
        repeat (3) tick();
        check_reset_state("reset");
        rst = 1'b0;
        tick();

        // Abort in IDLE has no effect.
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("idle_abort_busy", bus.busy, 0);
        chk("idle_abort_done", bus.done, 0);

        for (int i = 0; i < 3; i++) run_dump(tbl[i]);

        // Abort during the second READ of a 10-word range.
        clear_log();
        bus.start_addr = 16'h0100;
        bus.end_addr   = 16'h0109;
        bus.dump_ready = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        guard = 0;
        while (!(bus.ram_en && bus.address_bus == 16'h0101) && guard < 50) begin
            tick();
            guard++;
        end
        chk("abort_reached_read2", guard < 50, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_done",   bus.done, 1);
        chk("abort_valid",  bus.dump_valid, 0);
        chk("abort_halt",   bus.halt, 0);
        chk("abort_oe",     bus.bus_oe, 0);
        chk("abort_ram_en", bus.ram_en, 0);
        chk("abort_words",  got_addr.size(), 1);
        tick();
        chk("abort_idle", bus.busy, 0);

        // New STARTs after abort, a stall, a start-while-busy, random ready.
        for (int i = 3; i < 6; i++) run_dump(tbl[i]);

        // Reset while a word is waiting in OUT.
        clear_log();
        bus.start_addr = 16'h0200;
        bus.end_addr   = 16'h0203;
        bus.dump_ready = 1'b0;
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
        guard = 0;
        while (!bus.dump_valid && guard < 50) begin
            tick();
            guard++;
        end
        chk("reset_reached_out", bus.dump_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("midreset");
        repeat (3) tick();
        chk("midreset_no_done", done_cnt, 0);

        // Random ranges, some straddling the top of memory.
        for (int k = 0; k < 8; k++) begin
            rs  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFA + $urandom_range(0, 5)) : 16'($urandom);
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) mem[16'(rs + 16'(j))] = 16'($urandom);
            rv.s          = rs;
            rv.e          = 16'(rs + 16'(len - 1));
            rv.exp_words  = len;
            rv.exp_last   = rv.e;
            rv.rnd_ready  = 1'b1;
            rv.stall_beat = -1;
            rv.glitch     = 1'b0;
            run_dump(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/bat_amateur_mem_dump.md
Name: bat_amateur_mem_dump

Overview:
- RAM readback master: halts the CPU, takes the shared RAM address/data bus, reads an inclusive address range, and streams each word out over a valid/ready interface.
- This is the read-side counterpart of the bench/loader path that writes program and data words into RAM under HALT.
- Sits beside the CPU at top level. The top level tristates ADDRESS_BUS, RAM_EN and RAM_RW using BUS_OE.
- Used for post-run memory inspection, for example reading back a Fibonacci result area.

Parameters:
- ADDRESS_WIDTH, 16: width of the address bus and of the address registers.
- DATA_WIDTH, 16: width of a RAM word.
- RAM_READ_LATENCY, 1: cycles from the address/RAM_EN being presented to DATA_BUS being valid. Must be at least 1.
- HALT_SETTLE, 2: cycles HALT is held before the bus is taken. Must be at least 1.

Ports:
- CLK  in  1  system clock; all logic updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle request; sampled only in IDLE.
- ABORT  in  1  terminate the dump early.
- START_ADDR  in  ADDRESS_WIDTH  first address to read.
- END_ADDR  in  ADDRESS_WIDTH  last address to read (inclusive).
- HALT  out  1  CPU halt request.
- BUS_OE  out  1  high while this block drives ADDRESS_BUS, RAM_EN and RAM_RW.
- ADDRESS_BUS  out  ADDRESS_WIDTH  RAM address.
- RAM_EN  out  1  RAM enable.
- RAM_RW  out  1  RAM direction: 1 = read. This block never drives 0.
- DATA_BUS  in  DATA_WIDTH  read data returned by the RAM.
- DUMP_DATA  out  DATA_WIDTH  captured word.
- DUMP_ADDR  out  ADDRESS_WIDTH  address of DUMP_DATA.
- DUMP_VALID  out  1  stream valid.
- DUMP_READY  in  1  stream ready.
- BUSY  out  1  high in every state other than IDLE.
- DONE  out  1  one-cycle pulse when the bus is released.

Behaviour:
- Reset values: HALT=0, BUS_OE=0, ADDRESS_BUS=0, RAM_EN=0, RAM_RW=1, DUMP_DATA=0, DUMP_ADDR=0, DUMP_VALID=0, BUSY=0, DONE=0, state=IDLE.
- Reset mid-operation: the same values apply at the next edge, so HALT drops and the bus is released. No DONE pulse is produced.
- All outputs are registered.
- FSM states: IDLE, SETTLE, READ, OUT, RELEASE.
- IDLE:
  - All outputs are at their reset values except DUMP_DATA and DUMP_ADDR, which hold their last values.
  - START=1 latches START_ADDR into cur and END_ADDR into last, sets HALT=1, loads the settle counter with HALT_SETTLE, and moves to SETTLE.
- SETTLE:
  - HALT=1, BUS_OE=0.
  - The counter decrements each cycle. When it reaches 0, go to READ.
- READ:
  - BUS_OE=1, RAM_EN=1, RAM_RW=1, ADDRESS_BUS=cur.
  - Held for exactly RAM_READ_LATENCY cycles.
  - On the edge ending the last READ cycle: DUMP_DATA<=DATA_BUS, DUMP_ADDR<=cur, DUMP_VALID<=1, RAM_EN<=0, then go to OUT.
- OUT:
  - BUS_OE=1, HALT=1, and DUMP_VALID holds with stable DATA/ADDR until a cycle where DUMP_VALID and DUMP_READY are both 1.
  - On that handshake DUMP_VALID<=0.
  - If cur==last, go to RELEASE. Otherwise cur<=cur+1 (modulo 2^ADDRESS_WIDTH) and go to READ.
- RELEASE (exactly one cycle): BUS_OE=0, RAM_EN=0, HALT=0, DONE=1, then go to IDLE.
- Throughput with DUMP_READY held high: RAM_READ_LATENCY+1 cycles per word.
- Word count = ((last-cur) mod 2^ADDRESS_WIDTH)+1.
  - END_ADDR==START_ADDR reads exactly one word.
  - END_ADDR<START_ADDR wraps through 0xFFFF to 0x0000.
- Simultaneous events:
  - START while BUSY is ignored.
  - ABORT in SETTLE, READ or OUT forces RELEASE on the next edge. DUMP_VALID is cleared without a handshake and DONE still pulses.
  - ABORT in IDLE is ignored.
  - ABORT and START together in IDLE: START wins.
  - ABORT in the same cycle as an OUT handshake: the word counts as delivered, then RELEASE.
- HALT is high from the edge after START through the end of the last OUT/abort cycle. It is low in the RELEASE cycle.
- BUS_OE is never high while HALT is low.

Test Plan:
1. RAM preloaded 0x0010=1, 0x0011=0, 0x0012=1; START with 0x0010..0x0012; DUMP_READY=1 -> three beats (0x0010,1), (0x0011,0), (0x0012,1); one word every 2 cycles; DONE pulses once; HALT returns to 0 in the DONE cycle.
2. Range 0x0005..0x0005 -> exactly one beat with addr 0x0005; DONE follows 1 cycle after the handshake.
3. Range 0xFFFE..0x0001 -> four beats with addresses FFFE, FFFF, 0000, 0001 in that order.
4. DUMP_READY low for 5 cycles during the second beat -> DUMP_VALID, DUMP_DATA and DUMP_ADDR stable for the whole stall; RAM_EN=0; HALT=1; no address advance.
5. ABORT during the second READ of a 10-word range -> RELEASE next cycle; DONE=1; DUMP_VALID=0; HALT=0. A new START is then accepted normally.
6. RESET asserted during OUT -> every output at its reset value after the edge, with no DONE. START pulsed while BUSY in a separate run -> ignored; the range is unchanged.
